// File: rtl/acc_seq.sv
// acc_seq: single-outstanding accumulator sequencer driving an external add/sub stage.
// Build option ACC_SAT_EN: saturate ADD/SUB results on signed overflow.
module acc_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic [3:0] acc,
    output logic [3:0] flags,
    output logic       rsp_valid,
    input  logic       rsp_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [2:0] op_r;
    logic [3:0] data_r;
    logic [3:0] acc_r;
    logic [3:0] flags_r;
    logic [3:0] acc_nxt_s;
    logic [3:0] flags_nxt_s;
    logic       cmd_ready_r;
    logic       rsp_valid_r;
    logic [3:0] alu_b_r;
    logic       alu_cin_r;
    logic       accept_s;
`ifdef ACC_SAT_EN
    logic [3:0] sat_acc_s;
`endif

    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic z, input logic n);
        return {c, v, z, n};
    endfunction

    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign acc       = acc_r;
    assign flags     = flags_r;
    assign alu_a     = acc_r;
    assign alu_b     = alu_b_r;
    assign alu_cin   = alu_cin_r;
    assign accept_s  = cmd_valid & (state_r == ST_IDLE);

    // Next-state logic for the IDLE -> EXEC -> RESP handshake sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Accumulator and flag values committed at the edge that ends EXEC.
    always_comb begin
        acc_nxt_s   = acc_r;
        flags_nxt_s = flags_r;
`ifdef ACC_SAT_EN
        sat_acc_s   = alu_result[3] ? 4'b0111 : 4'b1000;
`endif
        case (op_r)
            OP_LOAD: begin
                acc_nxt_s   = data_r;
                flags_nxt_s = pack_flags(1'b0, 1'b0, (data_r == 4'd0), data_r[3]);
            end
            OP_ADD, OP_SUB: begin
`ifdef ACC_SAT_EN
                if (alu_overflow) begin
                    acc_nxt_s   = sat_acc_s;
                    flags_nxt_s = pack_flags(alu_carry, 1'b1, (sat_acc_s == 4'd0), sat_acc_s[3]);
                end else begin
                    acc_nxt_s   = alu_result;
                    flags_nxt_s = pack_flags(alu_carry, alu_overflow, alu_zero, alu_result[3]);
                end
`else
                acc_nxt_s   = alu_result;
                flags_nxt_s = pack_flags(alu_carry, alu_overflow, alu_zero, alu_result[3]);
`endif
            end
            OP_CMP: begin
                flags_nxt_s = pack_flags(alu_carry, alu_overflow, alu_zero, alu_result[3]);
            end
            OP_CLR: begin
                acc_nxt_s   = 4'd0;
                flags_nxt_s = 4'b0010;
            end
            default: begin
                acc_nxt_s   = acc_r;
                flags_nxt_s = flags_r;
            end
        endcase
    end

    // State, latched command, registered handshake/ALU outputs and architectural state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= 3'd0;
            data_r      <= 4'd0;
            acc_r       <= 4'd0;
            flags_r     <= 4'd0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            alu_b_r     <= 4'd0;
            alu_cin_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            // ALU operand/select registers are non-zero only for the single EXEC cycle.
            if (accept_s) begin
                op_r      <= cmd_op;
                data_r    <= cmd_data;
                alu_b_r   <= cmd_data;
                alu_cin_r <= (cmd_op == OP_SUB) || (cmd_op == OP_CMP);
            end else begin
                alu_b_r   <= 4'd0;
                alu_cin_r <= 1'b0;
            end
            if (state_r == ST_EXEC) begin
                acc_r   <= acc_nxt_s;
                flags_r <= flags_nxt_s;
            end else begin
                acc_r   <= acc_r;
                flags_r <= flags_r;
            end
        end
    end

endmodule

// File: tb/tb_acc_seq.sv
// Self-checking bench for acc_seq: directed vector table, handshake/reset corner cases,
// and randomized commands against an integer-arithmetic reference model.
module tb_acc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_zero;
    logic [3:0] acc;
    logic [3:0] flags;
    logic       rsp_valid;
    logic       rsp_ready;

    int total = 0;
    int bad   = 0;
    logic [3:0] m_acc;
    logic [3:0] m_flags;

    always #5 clk = ~clk;

    acc_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero), .acc(acc), .flags(flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready)
    );

    // External add/sub stage: a + (b or ~b) + cin.
    logic [3:0] alu_bb;
    logic [4:0] alu_sum;
    assign alu_bb       = alu_cin ? ~alu_b : alu_b;
    assign alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + {4'b0000, alu_cin};
    assign alu_result   = alu_sum[3:0];
    assign alu_carry    = alu_sum[4];
    assign alu_overflow = (alu_a[3] == alu_bb[3]) && (alu_sum[3] != alu_a[3]);
    assign alu_zero     = (alu_sum[3:0] == 4'd0);

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Reference model: plain unsigned/signed integer arithmetic.
    task automatic model_step(input logic [2:0] op, input logic [3:0] d);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [3:0] res;
        ua = int'(m_acc);
        ub = int'(d);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        case (op)
            3'd1: begin m_acc = d; m_flags = {2'b00, (d == 4'd0), d[3]}; end
            3'd2, 3'd3, 3'd4: begin
                if (op == 3'd2) begin r = ua + ub; sr = sa + sb; c = (r > 15); end
                else begin r = ua - ub; sr = sa - sb; c = (ua >= ub); end
                res = r[3:0];
                v = (sr > 7) || (sr < -8);
`ifdef ACC_SAT_EN
                if (v && op != 3'd4) res = (sr > 7) ? 4'b0111 : 4'b1000;
`endif
                m_flags = {c, v, (res == 4'd0), res[3]};
                if (op != 3'd4) m_acc = res;
            end
            3'd5: begin m_acc = 4'd0; m_flags = 4'b0010; end
            default: ;
        endcase
    endtask

    // One full command: accept, EXEC, RESP held `hold` cycles, then release.
    task automatic run_cmd(input string nm, input logic [2:0] op, input logic [3:0] d,
                           input int hold, output logic [3:0] a, output logic [3:0] f);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; rsp_ready = 1'b0;
        while (!cmd_ready && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) chk({nm, "_accept_timeout"}, 4'd1, 4'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({nm, "_exec_rsp_valid"}, {3'b000, rsp_valid}, 4'd0);
        chk({nm, "_exec_cmd_ready"}, {3'b000, cmd_ready}, 4'd0);
        chk({nm, "_exec_alu_cin"}, {3'b000, alu_cin}, {3'b000, (op == 3'd3 || op == 3'd4)});
        chk({nm, "_exec_alu_b"}, alu_b, d);
        chk({nm, "_exec_alu_a"}, alu_a, m_acc);
        model_step(op, d);
        @(negedge clk);
        chk({nm, "_latency2_rsp_valid"}, {3'b000, rsp_valid}, 4'd1);
        chk({nm, "_resp_alu_b"}, alu_b, 4'd0);
        a = acc; f = flags;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 4'hF;
            @(negedge clk);
            chk({nm, "_hold_rsp_valid"}, {3'b000, rsp_valid}, 4'd1);
            chk({nm, "_hold_cmd_ready"}, {3'b000, cmd_ready}, 4'd0);
            chk({nm, "_hold_acc"}, acc, a);
            chk({nm, "_hold_flags"}, flags, f);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_idle_cmd_ready"}, {3'b000, cmd_ready}, 4'd1);
        chk({nm, "_idle_rsp_valid"}, {3'b000, rsp_valid}, 4'd0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] acc;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [3:0] ra, rf;
        vecs[0]  = '{3'd1, 4'd5, 4'b0101, 4'b0000};
`ifdef ACC_SAT_EN
        vecs[1]  = '{3'd2, 4'd3, 4'b0111, 4'b0100};
`else
        vecs[1]  = '{3'd2, 4'd3, 4'b1000, 4'b0101};
`endif
        vecs[2]  = '{3'd1, 4'd3, 4'b0011, 4'b0000};
        vecs[3]  = '{3'd3, 4'd3, 4'b0000, 4'b1010};
        vecs[4]  = '{3'd1, 4'd2, 4'b0010, 4'b0000};
        vecs[5]  = '{3'd4, 4'd5, 4'b0010, 4'b0001};
        vecs[6]  = '{3'd5, 4'd0, 4'b0000, 4'b0010};
        vecs[7]  = '{3'd1, 4'd8, 4'b1000, 4'b0001};
`ifdef ACC_SAT_EN
        vecs[8]  = '{3'd3, 4'd1, 4'b1000, 4'b1101};
        vecs[9]  = '{3'd6, 4'd9, 4'b1000, 4'b1101};
        vecs[10] = '{3'd0, 4'd3, 4'b1000, 4'b1101};
`else
        vecs[8]  = '{3'd3, 4'd1, 4'b0111, 4'b1100};
        vecs[9]  = '{3'd6, 4'd9, 4'b0111, 4'b1100};
        vecs[10] = '{3'd0, 4'd3, 4'b0111, 4'b1100};
`endif

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_acc", acc, 4'd0);
        chk("reset_flags", flags, 4'd0);
        chk("reset_rsp_valid", {3'b000, rsp_valid}, 4'd0);
        chk("reset_cmd_ready", {3'b000, cmd_ready}, 4'd1);
        rst = 1'b0;
        m_acc = 4'd0; m_flags = 4'd0;

        for (int i = 0; i < 11; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, 0, ra, rf);
            chk($sformatf("vec%0d_acc", i), ra, vecs[i].acc);
            chk($sformatf("vec%0d_flags", i), rf, vecs[i].flags);
        end

        // RESP held three cycles while a new command is offered.
        run_cmd("hold3", 3'd1, 4'd9, 3, ra, rf);
        chk("hold3_acc", ra, 4'd9);
        chk("hold3_flags", rf, 4'b0001);

        // Illegal opcode 111 with acc = 6, flags = 1000.
        run_cmd("pre111a", 3'd1, 4'd15, 0, ra, rf);
        run_cmd("pre111b", 3'd2, 4'd7, 0, ra, rf);
        chk("pre111_acc", ra, 4'd6);
        chk("pre111_flags", rf, 4'b1000);
        run_cmd("op111", 3'd7, 4'd5, 1, ra, rf);
        chk("op111_acc", ra, 4'd6);
        chk("op111_flags", rf, 4'b1000);

        // Reset during EXEC of ADD 7 with acc = 4.
        run_cmd("pre_rst", 3'd1, 4'd4, 0, ra, rf);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 4'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_exec_alu_b", alu_b, 4'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exec_acc", acc, 4'd0);
        chk("rst_exec_flags", flags, 4'd0);
        chk("rst_exec_rsp_valid", {3'b000, rsp_valid}, 4'd0);
        chk("rst_exec_cmd_ready", {3'b000, cmd_ready}, 4'd1);
        @(negedge clk);
        chk("rst_exec_dropped", {3'b000, rsp_valid}, 4'd0);
        m_acc = 4'd0; m_flags = 4'd0;

        // Reset wins over a simultaneous accept.
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'd3; rst = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b0;
        chk("rst_accept_cmd_ready", {3'b000, cmd_ready}, 4'd1);
        chk("rst_accept_alu_b", alu_b, 4'd0);
        @(negedge clk);
        chk("rst_accept_no_resp", {3'b000, rsp_valid}, 4'd0);
        chk("rst_accept_acc", acc, 4'd0);

        for (int k = 0; k < 200; k++) begin
            logic [2:0] op;
            logic [3:0] d;
            op = 3'($urandom_range(0, 7));
            d  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_cmd("rnd", op, d, int'($urandom_range(0, 2)), ra, rf);
            chk($sformatf("rnd%0d_acc", k), ra, m_acc);
            chk($sformatf("rnd%0d_flags", k), rf, m_flags);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_seq.md
ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-003 SHALL have port cmd_valid  in  1  command offered.
REQ-004 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-005 SHALL have port cmd_op  in  3  opcode: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 CMP, 101 CLR, 110/111 illegal.
REQ-006 SHALL have port cmd_data  in  4  operand.
REQ-007 SHALL have ports alu_a, alu_b  out  4  operands driven to the add/sub stage.
REQ-008 SHALL have port alu_cin  out  1  add/sub select to the stage (1 = subtract).
REQ-009 SHALL have ports alu_result  in  4, alu_carry, alu_overflow, alu_zero  in  1 each  combinational returns from the add/sub stage.
REQ-010 SHALL have port acc  out  4  accumulator.
REQ-011 SHALL have port flags  out  4  {C,V,Z,N}, bit3 = C, bit0 = N.
REQ-012 SHALL have ports rsp_valid  out  1, rsp_ready  in  1  completion handshake.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; cmd_ready = 1 only in IDLE; at most one command outstanding.
REQ-014 SHALL, in IDLE on cmd_valid & cmd_ready, latch cmd_op/cmd_data and enter EXEC next cycle.
REQ-015 SHALL, in EXEC, drive alu_a = acc, alu_b = latched data, alu_cin = 1 for SUB/CMP else 0; outside EXEC drive alu_a = acc, alu_b = 0, alu_cin = 0.
REQ-016 SHALL commit acc/flags at the clock edge ending EXEC and enter RESP; rsp_valid = 1 in RESP only.
REQ-017 SHALL hold RESP, acc, flags stable until rsp_ready = 1, then return to IDLE next cycle; accept-to-rsp_valid latency is exactly 2 cycles.
REQ-018 SHALL for ADD/SUB write acc = alu_result, C = alu_carry, V = alu_overflow, Z = alu_zero, N = alu_result[3] (modulo-16 wrap).
REQ-019 SHALL for CMP update flags as SUB but leave acc unchanged.
REQ-020 SHALL for LOAD write acc = data, C = 0, V = 0, Z = (data == 0), N = data[3].
REQ-021 SHALL for CLR write acc = 0, flags = 0010.
REQ-022 SHALL for NOP and illegal opcodes leave acc and flags unchanged but still complete the RESP handshake.
REQ-023 SHALL ignore cmd_valid outside IDLE; upstream holds the command until accepted.

Reset
REQ-024 SHALL, when rst = 1 at a clock edge, set state IDLE, acc = 0, flags = 0000, rsp_valid = 0, cmd_ready = 1 next cycle, regardless of state (including mid-EXEC/RESP, where the pending command is dropped).
REQ-025 SHALL let rst override any simultaneous cmd accept or commit.

Configuration
REQ-026 SHALL, with ACC_SAT_EN defined, saturate ADD/SUB on alu_overflow = 1: acc = 0111 if alu_result[3] = 1, else 1000; V = 1, C = alu_carry, Z/N from the written acc.
REQ-027 SHALL, without ACC_SAT_EN, wrap per REQ-018; CMP never saturates in either build.

Verification
REQ-028 SHALL verify LOAD 5, ADD 3 -> acc = 1000, flags = 0101 (no macro); with ACC_SAT_EN acc = 0111, flags = 0100.
REQ-029 SHALL verify LOAD 3, SUB 3 -> acc = 0000, flags = 1010.
REQ-030 SHALL verify LOAD 2, CMP 5 -> acc = 0010, flags = 0001, alu_cin = 1 during EXEC.
REQ-031 SHALL verify rsp_ready held low 3 cycles in RESP -> rsp_valid stays 1, cmd_ready stays 0, acc/flags stable, IDLE one cycle after rsp_ready rises.
REQ-032 SHALL verify rst asserted during EXEC of ADD 7 with acc = 4 -> next cycle acc = 0, flags = 0000, rsp_valid = 0, cmd_ready = 1.
REQ-033 SHALL verify opcode 111 with acc = 6, flags = 1000 -> values unchanged, rsp_valid asserted 2 cycles after accept.
